sram_arbiter: RTL

- Shares the board's 16-bit asynchronous SRAM (256K x 16) between two 32-bit requesters: port 0 = LSU data port, port 1 = secondary master (instruction prefetch / DMA).
- Arbitrates, then splits each 32-bit word access into two sequenced 16-bit SRAM phases with programmable wait states.
- Returns a one-cycle ack to the winning port.
- The LSU/ctrl_fsm stall path waits on o_ack0. The top level builds the tri-state dq bus from o_sram_dq_o/o_sram_dq_oe.

---
 rtl/sram_arbiter_if.sv | 33 +++
 rtl/sram_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pin bundle for sram_arbiter; the slave modport is the arbiter side,
// the master modport is the requester/pad side.
interface sram_arbiter_if;
  logic        i_req0, i_req1;
  logic        i_we0, i_we1;
  logic [18:0] i_addr0, i_addr1;
  logic [31:0] i_wdata0, i_wdata1;
  logic [3:0]  i_bmask0, i_bmask1;
  logic [31:0] o_rdata0, o_rdata1;
  logic        o_ack0, o_ack1;
  logic        o_busy;
  logic [17:0] o_sram_addr;
  logic [15:0] o_sram_dq_o;
  logic        o_sram_dq_oe;
  logic [15:0] i_sram_dq_i;
  logic        o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n;

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
    input  i_wdata0, i_wdata1, i_bmask0, i_bmask1, i_sram_dq_i,
    output o_rdata0, o_rdata1, o_ack0, o_ack1, o_busy,
    output o_sram_addr, o_sram_dq_o, o_sram_dq_oe,
    output o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n
  );

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
    output i_wdata0, i_wdata1, i_bmask0, i_bmask1, i_sram_dq_i,
    input  o_rdata0, o_rdata1, o_ack0, o_ack1, o_busy,
    input  o_sram_addr, o_sram_dq_o, o_sram_dq_oe,
    input  o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter for a 16-bit async SRAM: each 32-bit access becomes LO/HI halfword phases.
// Define SRAM_ARB_RR_EN for round-robin tie breaking; otherwise port 0 wins ties.
module sram_arbiter #(
  parameter int WAIT_CYC = 1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  sram_arbiter_if.slave bus,
  output logic [1:0]    o_dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_e;

  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYC);

  // Requester handshake: req and its inputs stay stable until the one-cycle ack;
  // req is low in the cycle after ack unless a new access follows, and IDLE samples then.
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [16:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [15:0] rlo_q, rlo_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] dq_o_q, dq_o_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic        lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
`ifdef SRAM_ARB_RR_EN
  logic        ptr_q, ptr_d;
`endif

  logic        any_req, win, last, phase_d, hi_d;
  logic [18:0] sel_addr;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^sel_addr[1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    bmask_d     = bmask_q;
    rlo_d       = rlo_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    any_req     = bus.i_req0 | bus.i_req1;
    last        = (cnt_q == 3'd0);
`ifdef SRAM_ARB_RR_EN
    ptr_d       = ptr_q;
    win         = bus.i_req1 & (~bus.i_req0 | ptr_q);
`else
    win         = ~bus.i_req0;
`endif
    sel_addr    = win ? bus.i_addr1 : bus.i_addr0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = win;
          we_d    = win ? bus.i_we1    : bus.i_we0;
          waddr_d = sel_addr[18:2];
          wdata_d = win ? bus.i_wdata1 : bus.i_wdata0;
          bmask_d = win ? bus.i_bmask1 : bus.i_bmask0;
          cnt_d   = WAIT_LD;
`ifdef SRAM_ARB_RR_EN
          ptr_d   = ~win;
`endif
          if (we_d && bmask_d == 4'd0)           state_d = DONE;
          else if (we_d && bmask_d[1:0] == 2'd0) state_d = HI;
          else                                   state_d = LO;
        end
      end
      LO: begin
        if (!last) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          if (!we_q) rlo_d = bus.i_sram_dq_i;
          cnt_d   = WAIT_LD;
          state_d = (we_q && bmask_q[3:2] == 2'd0) ? DONE : HI;
        end
      end
      HI: begin
        if (!last) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          // The high halfword arrives on the same edge that enters DONE.
          if (!we_q && !gnt_q) rdata0_d = {bus.i_sram_dq_i, rlo_q};
          if (!we_q &&  gnt_q) rdata1_d = {bus.i_sram_dq_i, rlo_q};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin outputs are computed from next-state values so every strobe leaves a flop.
    phase_d     = (state_d == LO) || (state_d == HI);
    hi_d        = (state_d == HI);
    ce_n_d      = ~phase_d;
    oe_n_d      = ~(phase_d & ~we_d);
    we_n_d      = ~(phase_d & we_d & (cnt_d != 3'd0));
    lb_n_d      = ~phase_d | (we_d & ~(hi_d ? bmask_d[2] : bmask_d[0]));
    ub_n_d      = ~phase_d | (we_d & ~(hi_d ? bmask_d[3] : bmask_d[1]));
    dq_oe_d     = phase_d & we_d;
    sram_addr_d = phase_d ? {waddr_d, hi_d} : sram_addr_q;
    dq_o_d      = dq_oe_d ? (hi_d ? wdata_d[31:16] : wdata_d[15:0]) : dq_o_q;
    ack0_d      = (state_d == DONE) & ~gnt_d;
    ack1_d      = (state_d == DONE) &  gnt_d;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= 17'd0;
      wdata_q     <= 32'd0;
      bmask_q     <= 4'd0;
      rlo_q       <= 16'd0;
      sram_addr_q <= 18'd0;
      dq_o_q      <= 16'd0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
`ifdef SRAM_ARB_RR_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      bmask_q     <= bmask_d;
      rlo_q       <= rlo_d;
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef SRAM_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.o_sram_addr  = sram_addr_q;
  assign bus.o_sram_dq_o  = dq_o_q;
  assign bus.o_sram_dq_oe = dq_oe_q;
  assign bus.o_sram_ce_n  = ce_n_q;
  assign bus.o_sram_we_n  = we_n_q;
  assign bus.o_sram_oe_n  = oe_n_q;
  assign bus.o_sram_lb_n  = lb_n_q;
  assign bus.o_sram_ub_n  = ub_n_q;
  assign bus.o_ack0       = ack0_q;
  assign bus.o_ack1       = ack1_q;
  assign bus.o_rdata0     = rdata0_q;
  assign bus.o_rdata1     = rdata1_q;
  assign bus.o_busy       = (state_q != IDLE);
  assign o_dbg_state      = state_q;
endmodule
